piece_fall_ctrl: RTL and testbench

//  Upstream of the tetromino pixel-address generator: drives its piece type and vertical position.

---
 rtl/tetris_pkg.sv | 36 +++
 rtl/lfsr8.sv | 19 +
 rtl/piece_fall_ctrl.sv | 136 +++++++++++++
 tb/tb_piece_fall_ctrl.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/tetris_pkg.sv
// rtl/tetris_pkg.sv - shared piece codes, heights, geometry defaults and fall FSM states
package tetris_pkg;

    localparam logic [2:0] PIECE_I = 3'd0;
    localparam logic [2:0] PIECE_J = 3'd1;
    localparam logic [2:0] PIECE_L = 3'd2;
    localparam logic [2:0] PIECE_O = 3'd3;
    localparam logic [2:0] PIECE_Z = 3'd4;
    localparam logic [2:0] PIECE_T = 3'd5;
    localparam logic [2:0] PIECE_S = 3'd6;

    localparam int unsigned STEP_DEFAULT    = 32;
    localparam int unsigned FLOOR_Y_DEFAULT = 480;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SPAWN  = 2'd1,
        FALL   = 2'd2,
        LANDED = 2'd3
    } fall_state_t;

    // Bounding-box height in pixels; the address generator uses the same table.
    function automatic logic [9:0] piece_height(input logic [2:0] id);
        case (id)
            PIECE_I: return 10'd128;
            PIECE_O: return 10'd64;
            default: return 10'd96;
        endcase
    endfunction

    // Code 7 has no piece, so it folds onto I.
    function automatic logic [2:0] piece_from_lfsr(input logic [7:0] v);
        return (v[2:0] == 3'd7) ? PIECE_I : v[2:0];
    endfunction

endpackage

// File: rtl/lfsr8.sv
// rtl/lfsr8.sv - free-running 8-bit Fibonacci LFSR, taps x^8+x^6+x^5+x^4+1
module lfsr8 #(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    output logic [7:0] q
);

    // Shift left every cycle; feedback from taps 8,6,5,4 keeps the sequence maximal and non-zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= SEED;
        end else begin
            q <= {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
        end
    end

endmodule

// File: rtl/piece_fall_ctrl.sv
// rtl/piece_fall_ctrl.sv - piece selection, timed fall, floor detection and landed handshake
module piece_fall_ctrl
    import tetris_pkg::*;
#(
    parameter int unsigned TICK_DIV   = 25_000_000,
    parameter int unsigned FAST_SHIFT = 3,
    parameter int unsigned STEP       = STEP_DEFAULT,
    parameter int unsigned FLOOR_Y    = FLOOR_Y_DEFAULT,
    parameter logic [7:0]  LFSR_SEED  = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       drop,
    input  logic       land_ack,
    output logic [2:0] piece_id,
    output logic [8:0] position,
    output logic       piece_valid,
    output logic       landed
);

    localparam int unsigned CW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned FAST_DIV = ((TICK_DIV >> FAST_SHIFT) > 0) ? (TICK_DIV >> FAST_SHIFT) : 1;
    localparam logic [CW-1:0] SLOW_LAST = CW'(TICK_DIV - 1);
    localparam logic [CW-1:0] FAST_LAST = CW'(FAST_DIV - 1);

    fall_state_t   state;
    fall_state_t   state_next;
    logic [CW-1:0] tick_cnt;
    logic [CW-1:0] tick_cnt_d;
    logic [8:0]    position_d;
    logic [2:0]    piece_id_d;
    logic          piece_valid_d;
    logic          landed_d;
    logic [7:0]    lfsr_q;
    logic [2:0]    candidate;
    logic          tick;
    logic [9:0]    fall_sum;
    logic          fits;

    lfsr8 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk (clk),
        .rst (rst),
        .q   (lfsr_q)
    );

    assign candidate = piece_from_lfsr(lfsr_q);

    // A drop that arrives late in the slow count ticks at once because of the >= compare.
    assign tick     = (state == FALL) && (tick_cnt >= (drop ? FAST_LAST : SLOW_LAST));
    assign fall_sum = {1'b0, position} + 10'(STEP) + piece_height(piece_id);
    assign fits     = (fall_sum <= 10'(FLOOR_Y));

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state: en low overrides everything, including a simultaneous land_ack.
    always_comb begin
        state_next = state;
        if (!en) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    state_next = SPAWN;
                SPAWN:   state_next = FALL;
                FALL:    if (tick && !fits) state_next = LANDED;
                LANDED:  if (land_ack) state_next = SPAWN;
                default: state_next = IDLE;
            endcase
        end
    end

    // Output/datapath next values, decided by the state being entered so every output is registered.
    always_comb begin
        position_d    = position;
        piece_id_d    = piece_id;
        tick_cnt_d    = tick_cnt;
        piece_valid_d = (state_next == FALL) || (state_next == LANDED);
        landed_d      = (state_next == LANDED);
        case (state_next)
            IDLE: begin
                position_d = '0;
                tick_cnt_d = '0;
            end
            SPAWN: begin
                piece_id_d = candidate;
                position_d = '0;
                tick_cnt_d = '0;
            end
            FALL: begin
                if (state == FALL) begin
                    if (tick) begin
                        tick_cnt_d = '0;
                        position_d = position + 9'(STEP);
                    end else begin
                        tick_cnt_d = tick_cnt + 1'b1;
                    end
                end else begin
                    tick_cnt_d = '0;
                end
            end
            LANDED: begin
                tick_cnt_d = '0;
            end
            default: begin
                tick_cnt_d = '0;
            end
        endcase
    end

    // Output and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            position    <= '0;
            piece_id    <= PIECE_I;
            piece_valid <= 1'b0;
            landed      <= 1'b0;
            tick_cnt    <= '0;
        end else begin
            position    <= position_d;
            piece_id    <= piece_id_d;
            piece_valid <= piece_valid_d;
            landed      <= landed_d;
            tick_cnt    <= tick_cnt_d;
        end
    end

endmodule

// File: tb/tb_piece_fall_ctrl.sv
// tb/tb_piece_fall_ctrl.sv - randomized self-checking bench for piece_fall_ctrl
module tb_piece_fall_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       drop;
    logic       land_ack;
    logic [2:0] piece_id;
    logic [8:0] position;
    logic       piece_valid;
    logic       landed;

    piece_fall_ctrl #(
        .TICK_DIV   (8),
        .FAST_SHIFT (1),
        .STEP       (32),
        .FLOOR_Y    (480),
        .LFSR_SEED  (8'hA5)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .drop        (drop),
        .land_ack    (land_ack),
        .piece_id    (piece_id),
        .position    (position),
        .piece_valid (piece_valid),
        .landed      (landed)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int heights [7] = '{128, 96, 96, 64, 96, 96, 96};
    int finals  [7] = '{352, 384, 384, 416, 384, 384, 384};

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: mode 0=idle 1=spawn 2=fall 3=landed.
    int         m_mode, m_id, m_pos, m_cnt, m_valid, m_landed;
    int         m_cand, m_period, spawns;
    logic [7:0] m_lfsr;
    bit         seen [7];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_mode = 0; m_id = 0; m_pos = 0; m_cnt = 0; m_valid = 0; m_landed = 0;
            m_lfsr = 8'hA5;
        end else begin
            m_cand = (m_lfsr[2:0] == 3'd7) ? 0 : int'(m_lfsr[2:0]);
            if (!en) begin
                m_mode = 0; m_pos = 0; m_cnt = 0; m_valid = 0; m_landed = 0;
            end else if (m_mode == 0) begin
                m_mode = 1; m_id = m_cand; spawns++;
            end else if (m_mode == 1) begin
                m_mode = 2; m_valid = 1; m_cnt = 0;
            end else if (m_mode == 2) begin
                m_period = drop ? 4 : 8;
                if (m_cnt >= m_period - 1) begin
                    m_cnt = 0;
                    if (m_pos + 32 + heights[m_id] <= 480) m_pos = m_pos + 32;
                    else begin m_mode = 3; m_landed = 1; end
                end else begin
                    m_cnt = m_cnt + 1;
                end
            end else if (land_ack) begin
                m_mode = 1; m_id = m_cand; m_landed = 0; m_valid = 0; m_pos = 0; spawns++;
            end
            m_lfsr = {m_lfsr[6:0], ^(m_lfsr & 8'hB8)};
        end
    end

    // Per-cycle comparison against the model.
    bit chk_on = 0;
    bit prev_landed = 0;
    always @(negedge clk) begin
        if (chk_on && !rst) begin
            check("piece_id", piece_id, m_id);
            check("position", position, m_pos);
            check("piece_valid", piece_valid, m_valid);
            check("landed", landed, m_landed);
            check("lfsr", dut.u_lfsr.q, m_lfsr);
            check("id_not7", piece_id == 3'd7, 0);
            check("lfsr_nonzero", dut.u_lfsr.q == 8'd0, 0);
            if (landed && !prev_landed && piece_id < 3'd7)
                check("final_pos", position, finals[piece_id]);
            if (m_mode == 1 && piece_id < 3'd7) seen[piece_id] = 1'b1;
            prev_landed = landed;
        end
    end

    initial begin
        int n;
        rst = 1'b1; en = 1'b0; drop = 1'b0; land_ack = 1'b0; spawns = 0;
        repeat (3) @(negedge clk);
        check("rst_pos", position, 0);
        check("rst_valid", piece_valid, 0);
        check("rst_landed", landed, 0);
        check("rst_id", piece_id, 0);
        chk_on = 1;
        rst = 1'b0; en = 1'b1;

        // First spawn from seed, then fall entry.
        @(negedge clk);
        check("t1_spawn_id", piece_id, 5);
        check("t1_spawn_valid", piece_valid, 0);
        @(negedge clk);
        check("t1_fall_valid", piece_valid, 1);
        check("t1_fall_pos", position, 0);

        // T lands at 384 and is held until acknowledged.
        for (n = 0; n < 400 && !landed; n++) @(negedge clk);
        check("t3_landed", landed, 1);
        check("t3_land_pos", position, 384);
        repeat (20) begin
            @(negedge clk);
            check("hold_landed", landed, 1);
            check("hold_pos", position, 384);
        end
        land_ack = 1'b1;
        @(negedge clk);
        land_ack = 1'b0;
        check("ack_landed", landed, 0);
        check("ack_pos", position, 0);

        // en dropped mid-fall at 128; acks in IDLE do nothing.
        for (n = 0; n < 300 && position != 9'd128; n++) @(negedge clk);
        check("t5_reach128", position, 128);
        en = 1'b0;
        @(negedge clk);
        check("t5_idle_pos", position, 0);
        check("t5_idle_valid", piece_valid, 0);
        land_ack = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("t5_ack_ignored", landed, 0);
        end
        land_ack = 1'b0;

        // Fast drop: 4 cycles per step, then 8 after release.
        en = 1'b1; drop = 1'b1;
        repeat (2) @(negedge clk);
        check("t4_start", position, 0);
        repeat (4) @(negedge clk);
        check("t4_fast1", position, 32);
        repeat (4) @(negedge clk);
        check("t4_fast2", position, 64);
        drop = 1'b0;
        repeat (7) @(negedge clk);
        check("t4_slow_hold", position, 64);
        @(negedge clk);
        check("t4_slow1", position, 96);

        // Asynchronous reset mid-fall.
        #2 rst = 1'b1;
        #1;
        check("arst_pos", position, 0);
        check("arst_valid", piece_valid, 0);
        check("arst_landed", landed, 0);
        check("arst_id", piece_id, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("arst_respawn_id", piece_id, 5);

        // Randomized play.
        for (int i = 0; i < 5000; i++) begin
            en = ($urandom_range(0, 299) != 0);
            if ($urandom_range(0, 19) == 0) drop = ~drop;
            land_ack = landed ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 29) == 0);
            @(negedge clk);
        end

        // Rapid respawn churn for piece distribution.
        spawns = 0;
        for (n = 0; n < 30000 && spawns < 1000; n++) begin
            en = ($urandom_range(0, 3) != 0);
            drop = $urandom_range(0, 1);
            land_ack = $urandom_range(0, 1);
            @(negedge clk);
        end
        check("spawn_count_reached", spawns >= 1000, 1);
        for (int k = 0; k < 7; k++) check($sformatf("seen_id_%0d", k), seen[k], 1);

        chk_on = 0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
